// File: rtl/timer_pkg.sv
// Shared types for the countdown timer: FSM state encoding, button
// indices and the BCD MM:SS value representation.
package timer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_MIN = 3'd1,
        SET_SEC = 3'd2,
        RUN     = 3'd3,
        PAUSE   = 3'd4,
        ALARM   = 3'd5
    } state_t;

    localparam int BTN_START = 0;
    localparam int BTN_MODE  = 1;
    localparam int BTN_INC   = 2;
    localparam int BTN_CLEAR = 3;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } mmss_t;

endpackage

// File: rtl/bcd_mmss_counter.sv
// MM:SS value register in BCD. Command priority is clr > load > inc_min >
// inc_sec > dec; the controller only ever raises one at a time.
module bcd_mmss_counter
    import timer_pkg::*;
#(
    parameter int MAX_MIN = 99
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr,
    input  logic  load,
    input  mmss_t load_val,
    input  logic  inc_min,
    input  logic  inc_sec,
    input  logic  dec,
    output mmss_t value,
    output logic  is_zero
);

    localparam bcd_t MAX_TENS = 4'(MAX_MIN / 10);
    localparam bcd_t MAX_ONES = 4'(MAX_MIN % 10);

    mmss_t nxt;

    // Next value: minute/second increments wrap independently, decrement
    // borrows through the seconds digits into the minutes.
    always_comb begin
        nxt = value;
        if (clr) begin
            nxt = '0;
        end else if (load) begin
            nxt = load_val;
        end else if (inc_min) begin
            if (value.min_tens == MAX_TENS && value.min_ones == MAX_ONES) begin
                nxt.min_tens = 4'd0;
                nxt.min_ones = 4'd0;
            end else if (value.min_ones == 4'd9) begin
                nxt.min_tens = value.min_tens + 4'd1;
                nxt.min_ones = 4'd0;
            end else begin
                nxt.min_ones = value.min_ones + 4'd1;
            end
        end else if (inc_sec) begin
            if (value.sec_tens == 4'd5 && value.sec_ones == 4'd9) begin
                nxt.sec_tens = 4'd0;
                nxt.sec_ones = 4'd0;
            end else if (value.sec_ones == 4'd9) begin
                nxt.sec_tens = value.sec_tens + 4'd1;
                nxt.sec_ones = 4'd0;
            end else begin
                nxt.sec_ones = value.sec_ones + 4'd1;
            end
        end else if (dec) begin
            if (value.sec_ones != 4'd0) begin
                nxt.sec_ones = value.sec_ones - 4'd1;
            end else begin
                nxt.sec_ones = 4'd9;
                if (value.sec_tens != 4'd0) begin
                    nxt.sec_tens = value.sec_tens - 4'd1;
                end else begin
                    nxt.sec_tens = 4'd5;
                    if (value.min_ones != 4'd0) begin
                        nxt.min_ones = value.min_ones - 4'd1;
                    end else begin
                        nxt.min_ones = 4'd9;
                        nxt.min_tens = value.min_tens - 4'd1;
                    end
                end
            end
        end
    end

    // Value register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value <= '0;
        else        value <= nxt;
    end

    assign is_zero = (value == '0);

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer control FSM: button prioritisation, mode sequencing and
// alarm hold counter. The MM:SS value lives in bcd_mmss_counter.
// Optional build macro TIMER_CTRL_RELOAD_EN adds a preset register that is
// captured on IDLE -> RUN and restored when the alarm returns to IDLE.
// The ALARM state literal is always written package-qualified because the
// ALARM output port shadows it inside this module.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int MAX_MIN     = 99,
    parameter int ALARM_TICKS = 10
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] BTN,
    input  logic       TICK,
    output bcd_t       MIN_TENS,
    output bcd_t       MIN_ONES,
    output bcd_t       SEC_TENS,
    output bcd_t       SEC_ONES,
    output state_t     STATE,
    output logic       EDIT_MIN,
    output logic       EDIT_SEC,
    output logic       ALARM
);

    localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

    state_t     state, nxt;
    logic [7:0] alarm_cnt;
    logic       alarm_inc;
    logic       b_clr, b_mode, b_start, b_inc;
    logic       cnt_clr, cnt_load, inc_min, inc_sec, dec;
    mmss_t      value, load_val;
    logic       is_zero, is_one;

    // Fixed priority CLEAR > MODE > START > INC; losers are dropped
    assign b_clr   = BTN[BTN_CLEAR];
    assign b_mode  = BTN[BTN_MODE]  & ~BTN[BTN_CLEAR];
    assign b_start = BTN[BTN_START] & ~BTN[BTN_MODE] & ~BTN[BTN_CLEAR];
    assign b_inc   = BTN[BTN_INC]   & ~BTN[BTN_START] & ~BTN[BTN_MODE] & ~BTN[BTN_CLEAR];

    assign is_one = (value == mmss_t'(16'h0001));

    // Next-state and counter command decode; a TICK is only acted on when
    // the winning button does nothing in the current state.
    always_comb begin
        nxt       = state;
        cnt_clr   = 1'b0;
        inc_min   = 1'b0;
        inc_sec   = 1'b0;
        dec       = 1'b0;
        alarm_inc = 1'b0;
        case (state)
            IDLE: begin
                if (b_clr)                    cnt_clr = 1'b1;
                else if (b_mode)              nxt = SET_MIN;
                else if (b_start && !is_zero) nxt = RUN;
            end
            SET_MIN: begin
                if (b_clr) begin
                    cnt_clr = 1'b1;
                    nxt     = IDLE;
                end else if (b_mode) nxt = SET_SEC;
                else if (b_inc)      inc_min = 1'b1;
            end
            SET_SEC: begin
                if (b_clr) begin
                    cnt_clr = 1'b1;
                    nxt     = IDLE;
                end else if (b_mode) nxt = IDLE;
                else if (b_inc)      inc_sec = 1'b1;
            end
            RUN: begin
                if (b_clr) begin
                    cnt_clr = 1'b1;
                    nxt     = IDLE;
                end else if (b_start) begin
                    nxt = PAUSE;
                end else if (TICK) begin
                    dec = 1'b1;
                    if (is_one) nxt = timer_pkg::ALARM;
                end
            end
            PAUSE: begin
                if (b_clr) begin
                    cnt_clr = 1'b1;
                    nxt     = IDLE;
                end else if (b_start) nxt = RUN;
            end
            timer_pkg::ALARM: begin
                if (|BTN) begin
                    nxt     = IDLE;
                    cnt_clr = b_clr;
                end else if (TICK) begin
                    if (alarm_cnt == ALARM_LAST) nxt = IDLE;
                    else                         alarm_inc = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

`ifdef TIMER_CTRL_RELOAD_EN
    mmss_t preset;

    // Preset captures the value at each start from IDLE; CLEAR zeros it
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                          preset <= '0;
        else if (cnt_clr)                    preset <= '0;
        else if (state == IDLE && nxt == RUN) preset <= value;
    end

    assign cnt_load = (state == timer_pkg::ALARM) && (nxt == IDLE) && !cnt_clr;
    assign load_val = preset;
`else
    assign cnt_load = 1'b0;
    assign load_val = '0;
`endif

    // State, mode flags and alarm counter; counter is zero whenever not in ALARM
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            EDIT_MIN  <= 1'b0;
            EDIT_SEC  <= 1'b0;
            ALARM     <= 1'b0;
            alarm_cnt <= 8'd0;
        end else begin
            state    <= nxt;
            EDIT_MIN <= (nxt == SET_MIN);
            EDIT_SEC <= (nxt == SET_SEC);
            ALARM    <= (nxt == timer_pkg::ALARM);
            if (nxt != timer_pkg::ALARM) alarm_cnt <= 8'd0;
            else if (alarm_inc)          alarm_cnt <= alarm_cnt + 8'd1;
        end
    end

    bcd_mmss_counter #(.MAX_MIN(MAX_MIN)) u_cnt (
        .clk      (CLK),
        .rst_n    (RST_N),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (load_val),
        .inc_min  (inc_min),
        .inc_sec  (inc_sec),
        .dec      (dec),
        .value    (value),
        .is_zero  (is_zero)
    );

    assign STATE    = state;
    assign MIN_TENS = value.min_tens;
    assign MIN_ONES = value.min_ones;
    assign SEC_TENS = value.sec_tens;
    assign SEC_ONES = value.sec_ones;

endmodule
